// File: rtl/bin_to_bcd_arb_seq_if.sv
// Handshake bundle for the shared binary-to-BCD converter: two request
// channels (val/rdy with 5-bit data) and one response channel tagged with
// the requester id.
interface bin_to_bcd_arb_seq_if;
  logic       req0_val;
  logic [4:0] req0_in;
  logic       req0_rdy;
  logic       req1_val;
  logic [4:0] req1_in;
  logic       req1_rdy;
  logic       resp_val;
  logic       resp_rdy;
  logic       resp_id;
  logic [3:0] resp_tens;
  logic [3:0] resp_ones;
  logic       busy;

  // Requesters and response consumer side
  modport master (
    output req0_val, req0_in, req1_val, req1_in, resp_rdy,
    input  req0_rdy, req1_rdy, resp_val, resp_id, resp_tens, resp_ones, busy
  );

  // Converter side
  modport slave (
    input  req0_val, req0_in, req1_val, req1_in, resp_rdy,
    output req0_rdy, req1_rdy, resp_val, resp_id, resp_tens, resp_ones, busy
  );
endinterface

// File: rtl/bin_to_bcd_arb_seq.sv
// Time-multiplexed 5-bit binary to 2-digit BCD converter shared by two
// requesters. Iterative double-dabble, one bit per cycle (5 cycles).
// Arbitration is round-robin by default; defining
// BIN_TO_BCD_ARB_FIXED_PRIORITY_EN makes req0 always win on contention.
module bin_to_bcd_arb_seq (
  input logic                 clk,
  input logic                 rst_n,
  bin_to_bcd_arb_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      state;
  logic [4:0]  bin;
  logic [7:0]  bcd;
  logic [2:0]  cnt;
  logic        id;
  logic        grant;
  logic        accept;
  logic [12:0] dabble_next;
`ifndef BIN_TO_BCD_ARB_FIXED_PRIORITY_EN
  logic        pri;
`endif

  // Grant selection: a lone requester wins, contention goes to the preferred one
  always_comb begin
    grant = 1'b0;
    if (bus.req0_val && bus.req1_val) begin
`ifdef BIN_TO_BCD_ARB_FIXED_PRIORITY_EN
      grant = 1'b0;
`else
      grant = pri;
`endif
    end else if (bus.req1_val) begin
      grant = 1'b1;
    end
  end

  assign accept       = (state == StIdle) && (bus.req0_val || bus.req1_val);
  assign bus.req0_rdy = (state == StIdle) && bus.req0_val && !grant;
  assign bus.req1_rdy = (state == StIdle) && bus.req1_val && grant;

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift left
  always_comb begin
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic [12:0] pre;
    tens = bcd[7:4];
    ones = bcd[3:0];
    if (tens >= 4'd5) tens = tens + 4'd3;
    if (ones >= 4'd5) ones = ones + 4'd3;
    pre = {tens, ones, bin};
    dabble_next = {pre[11:0], 1'b0};
  end

  // Control FSM with registered response and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      bin           <= 5'd0;
      bcd           <= 8'd0;
      cnt           <= 3'd0;
      id            <= 1'b0;
      bus.busy      <= 1'b0;
      bus.resp_val  <= 1'b0;
      bus.resp_id   <= 1'b0;
      bus.resp_tens <= 4'd0;
      bus.resp_ones <= 4'd0;
`ifndef BIN_TO_BCD_ARB_FIXED_PRIORITY_EN
      pri           <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            bin      <= grant ? bus.req1_in : bus.req0_in;
            bcd      <= 8'd0;
            id       <= grant;
            cnt      <= 3'd0;
            bus.busy <= 1'b1;
`ifndef BIN_TO_BCD_ARB_FIXED_PRIORITY_EN
            pri      <= ~grant;
`endif
            state    <= StConv;
          end
        end
        StConv: begin
          bcd <= dabble_next[12:5];
          bin <= dabble_next[4:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            // Last iteration: publish the finished digits straight from the datapath
            state         <= StDone;
            bus.resp_val  <= 1'b1;
            bus.resp_id   <= id;
            bus.resp_tens <= dabble_next[12:9];
            bus.resp_ones <= dabble_next[8:5];
          end
        end
        StDone: begin
          if (bus.resp_rdy) begin
            state        <= StIdle;
            bus.resp_val <= 1'b0;
            bus.busy     <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_arb_seq.sv
// Randomized self-checking bench for bin_to_bcd_arb_seq against a
// transaction-level model (value/10, value%10, arbitration by rule,
// response due 5 edges after accept). Honours BIN_TO_BCD_ARB_FIXED_PRIORITY_EN.
module tb_bin_to_bcd_arb_seq;

  logic clk;
  logic rst_n;
  bin_to_bcd_arb_seq_if bus ();

  bin_to_bcd_arb_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_active = 1'b0;
  int m_wait   = 0;
  bit m_pri    = 1'b0;
  bit m_id     = 1'b0;
  int m_v      = 0;
  bit acc0, acc1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_grant(input bit v0, input bit v1);
`ifdef BIN_TO_BCD_ARB_FIXED_PRIORITY_EN
    return !v0 && v1;
`else
    if (v0 && v1) return m_pri;
    return v1;
`endif
  endfunction

  // Called just after a negedge with inputs already driven; checks, advances model
  // across the next posedge and returns at the following negedge.
  task automatic step();
    bit g, gv, due;
    #1;
    gv  = bus.req0_val || bus.req1_val;
    g   = model_grant(bus.req0_val, bus.req1_val);
    due = m_active && (m_wait >= 5);
    check_val("req0_rdy", bus.req0_rdy, !m_active && gv && !g);
    check_val("req1_rdy", bus.req1_rdy, !m_active && gv && g);
    check_val("busy", bus.busy, m_active);
    check_val("resp_val", bus.resp_val, due);
    if (due) begin
      check_val("resp_tens", bus.resp_tens, m_v / 10);
      check_val("resp_ones", bus.resp_ones, m_v % 10);
      check_val("resp_id", bus.resp_id, m_id);
    end
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!m_active) begin
      if (gv) begin
        m_active = 1'b1;
        m_wait   = 0;
        m_id     = g;
        m_v      = g ? int'(bus.req1_in) : int'(bus.req0_in);
        m_pri    = ~g;
        acc0     = !g;
        acc1     = g;
      end
    end else if (due) begin
      if (bus.resp_rdy) m_active = 1'b0;
    end else begin
      m_wait++;
    end
    @(negedge clk);
  endtask

  task automatic drop_accepted();
    if (acc0) bus.req0_val = 1'b0;
    if (acc1) bus.req1_val = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.req0_val = 1'b0;
    bus.req0_in  = 5'd0;
    bus.req1_val = 1'b0;
    bus.req1_in  = 5'd0;
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state, with combinational grant visible while still in reset
    bus.req0_val = 1'b1;
    bus.req0_in  = 5'd31;
    #1;
    check_val("rst_resp_val", bus.resp_val, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_resp_id", bus.resp_id, 0);
    check_val("rst_resp_tens", bus.resp_tens, 0);
    check_val("rst_resp_ones", bus.resp_ones, 0);
    check_val("rst_req0_rdy", bus.req0_rdy, 1);
    check_val("rst_req1_rdy", bus.req1_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single conversion of 31 on req0
    step();
    drop_accepted();
    for (int i = 0; i < 8; i++) step();

    // Sweep 0..31 on req1 at minimum spacing
    for (int v = 0; v < 32; v++) begin
      bus.req1_val = 1'b1;
      bus.req1_in  = 5'(v);
      step();
      drop_accepted();
      for (int i = 0; i < 6; i++) step();
    end
    for (int i = 0; i < 3; i++) step();

    // Contention from reset: both held valid continuously
    @(negedge clk);
    rst_n    = 1'b0;
    m_active = 1'b0;
    m_pri    = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.req0_val = 1'b1;
    bus.req0_in  = 5'd7;
    bus.req1_val = 1'b1;
    bus.req1_in  = 5'd25;
    bus.resp_rdy = 1'b1;
    for (int i = 0; i < 42; i++) step();

    // Backpressure: both requesters waiting while the result is held in DONE
    while (m_active) step();
    bus.req0_in  = 5'd19;
    bus.resp_rdy = 1'b0;
    for (int i = 0; i < 16; i++) step();
    bus.resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.req0_val = 1'b0;
    bus.req1_val = 1'b0;
    while (m_active) step();

    // Reset during the 3rd CONV cycle; pri was left at 1 by the last grant to req0
    bus.req0_val = 1'b1;
    bus.req0_in  = 5'd23;
    step();
    drop_accepted();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_val("midrst_resp_val", bus.resp_val, 0);
    check_val("midrst_busy", bus.busy, 0);
    m_active     = 1'b0;
    m_pri        = 1'b0;
    bus.req0_val = 1'b0;
    bus.req1_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.req0_val = 1'b1;
    bus.req0_in  = 5'd12;
    bus.req1_val = 1'b1;
    bus.req1_in  = 5'd9;
    for (int i = 0; i < 16; i++) begin
      step();
      drop_accepted();
    end

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      if (!bus.req0_val && $urandom_range(0, 2) == 0) begin
        bus.req0_val = 1'b1;
        bus.req0_in  = 5'($urandom_range(0, 31));
      end
      if (!bus.req1_val && $urandom_range(0, 2) == 0) begin
        bus.req1_val = 1'b1;
        bus.req1_in  = 5'($urandom_range(0, 31));
      end
      bus.resp_rdy = ($urandom_range(0, 3) != 0);
      step();
      drop_accepted();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_arb_seq.md
# bin_to_bcd_arb_seq

Sequential, shared binary-to-BCD conversion unit for the lab display path. It accepts 5-bit unsigned values from two requesters through val/rdy handshakes and arbitrates between them. Each accepted value is converted over five cycles with an iterative shift-and-add-3 (double-dabble) datapath, and the result is returned as two BCD digits tagged with the requester id. This replaces one combinational decoder per display with a single time-multiplexed converter.

## Interface
- No parameters. Input width is fixed at 5 bits and output is two BCD digits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0_val  input  1  requester 0 has a value
- req0_in  input  5  requester 0 binary value, 0–31
- req0_rdy  output  1  requester 0 value accepted this cycle if req0_val
- req1_val  input  1  requester 1 has a value
- req1_in  input  5  requester 1 binary value
- req1_rdy  output  1  requester 1 value accepted this cycle if req1_val
- resp_val  output  1  result valid
- resp_rdy  input  1  consumer takes result
- resp_id  output  1  requester that owns the result
- resp_tens  output  4  BCD tens digit, 0–3
- resp_ones  output  4  BCD ones digit, 0–9
- busy  output  1  high in CONV or DONE

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE**
  - The arbiter picks a grant `g` among the valid requesters. `reqg_rdy` is asserted combinationally, and the other requester's rdy stays 0.
  - On `reqg_val && reqg_rdy`: capture `reqg_in` into `bin[4:0]`, set `bcd[7:0] = 0`, `id = g`, `cnt = 0`, and go to CONV.
  - If neither val is high, stay in IDLE. Both rdy are 0 in every state other than IDLE.
- **Arbitration** (default is round-robin)
  - A 1-bit pointer `pri` names the preferred requester. Reset value is 0.
  - If only one requester is valid, it is granted.
  - If both are valid, `pri` is granted.
  - After each accepted transfer, `pri` is set to `~g`.
  - `pri` is unchanged when no transfer occurs.
- **CONV**, one iteration per cycle:
  - For each BCD nibble, if the nibble is ≥5, add 3 to it.
  - Then shift `{bcd, bin}` left by 1, so `bin[4]` moves into `bcd[0]`.
  - Increment `cnt`. After the 5th iteration (`cnt` == 4 at the edge), go to DONE.
  - Nibble arithmetic is 4-bit. Inputs are ≤31, so the tens nibble never exceeds 3 and no carry out of bit 7 occurs.
- **DONE**
  - `resp_val = 1`, `resp_tens = bcd[7:4]`, `resp_ones = bcd[3:0]`, `resp_id = id`.
  - All response outputs hold stable while `resp_rdy` = 0.
  - On `resp_rdy` = 1, go to IDLE. There is no same-cycle re-accept: new requests are only accepted in IDLE.
- Requests arriving during CONV or DONE are held off (rdy = 0). Requesters must keep val and data stable until accepted.
- Value 0 converts to tens = 0, ones = 0 (no special case).

## Timing
- Reset (asynchronous, rst_n = 0) clears outputs and registers immediately:
  - state = IDLE, `pri` = 0
  - resp_val = 0, resp_id = 0, resp_tens = 0, resp_ones = 0, busy = 0
  - req0_rdy / req1_rdy follow IDLE arbitration once inputs are valid
- Reset mid-CONV or mid-DONE discards the in-flight value; no response is produced.
- Deassertion of rst_n is assumed synchronized upstream.
- Latency: with the accept at rising edge E, resp_val rises after edge E+5, i.e. 5 cycles later.
- Minimum request-to-request spacing is 7 cycles: accept, 5× CONV, 1× DONE with resp_rdy = 1, then the next accept in IDLE.
- busy is registered: high from edge E through the DONE-exit edge.

## Configuration
- Macro: `BIN_TO_BCD_ARB_FIXED_PRIORITY_EN`.
- **Undefined (default):** round-robin arbitration as described above.
- **Defined:**
  - Fixed priority; req0 always wins when both requesters are valid.
  - The `pri` register is not implemented.
  - req1 can starve if req0 stays valid continuously.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Single conversion, value 31.** Reset, then req0_val = 1 with req0_in = 31 and resp_rdy = 1. Required: req0_rdy = 1 in the first cycle; resp_val = 1 exactly 5 cycles later with tens = 3, ones = 1, id = 0.
- **Sweep.** Send values 0–31 on req1. Required for each: tens/ones equal value/10 and value%10 (e.g. 19 → 1,9; 10 → 1,0; 0 → 0,0), id = 1.
- **Contention.** After reset, hold both requesters valid (req0 = 7, req1 = 25) continuously. Required:
  - Default build: responses alternate 0,7 / 2,5 / 0,7 …, starting with id 0.
  - Fixed-priority build: only id 0 responses appear.
- **Backpressure.** Hold resp_rdy = 0 for 10 cycles in DONE. Required: resp_val, tens, ones and id stay stable; both rdy stay 0; resp_rdy = 1 returns the FSM to IDLE the next cycle.
- **Reset mid-operation.** Pulse rst_n low during the 3rd CONV cycle. Required: resp_val = 0 and busy = 0 immediately; no response for that value; the next request converts correctly and is granted to req0 first.
